pe_spad_feeder: RTL and testbench

// - Producer side of the PE spad write interface. Streams filter and ifmap pixels from upstream valid/ready buffers into one PE.
// - Drives filter_pixel/wr_filter and ifmap_pixel/wr_ifmap, and honours filter_spad_full/ifmap_spad_full.
// - Per run: loads p*q*S filter pixels, then streams ifmap_len ifmap pixels. Sits between the global buffer and a PE.

---
 rtl/pe_spad_feeder_pkg.sv | 9 +
 rtl/pe_spad_feeder_if.sv | 14 +
 rtl/pe_spad_feeder_out_stage.sv | 28 ++
 rtl/pe_spad_feeder.sv | 100 ++++++++++
 tb/tb_pe_spad_feeder.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/pe_spad_feeder_pkg.sv
// pe_spad_feeder_pkg: shared widths and FSM state encoding for the PE spad feeder.
package pe_feeder_pkg;
  localparam int S_WIDTH_DEF = 5;
  localparam int P_WIDTH_DEF = 5;
  localparam int Q_WIDTH_DEF = 3;
  localparam int FLEN_WIDTH = P_WIDTH_DEF + Q_WIDTH_DEF + S_WIDTH_DEF;
  localparam int STALL_WIDTH = 16;
  typedef enum logic [1:0] {IDLE, LOAD_FILTER, LOAD_IFMAP, DRAIN} state_t;
endpackage

// File: rtl/pe_spad_feeder_if.sv
// pe_spad_feeder_if: upstream valid/ready pixels and PE spad write strobes.
interface pe_spad_feeder_if #(parameter int DATA_WIDTH = 16);
  logic [DATA_WIDTH-1:0] filter_in, ifmap_in, filter_pixel, ifmap_pixel;
  logic filter_in_valid, filter_in_ready, ifmap_in_valid, ifmap_in_ready;
  logic wr_filter, wr_ifmap, filter_spad_full, ifmap_spad_full;
  modport master (
    input  filter_in, filter_in_valid, ifmap_in, ifmap_in_valid, filter_spad_full, ifmap_spad_full,
    output filter_in_ready, ifmap_in_ready, filter_pixel, wr_filter, ifmap_pixel, wr_ifmap
  );
  modport slave (
    output filter_in, filter_in_valid, ifmap_in, ifmap_in_valid, filter_spad_full, ifmap_spad_full,
    input  filter_in_ready, ifmap_in_ready, filter_pixel, wr_filter, ifmap_pixel, wr_ifmap
  );
endinterface

// File: rtl/pe_spad_feeder_out_stage.sv
// pe_out_stage: one-entry pipeline register whose write strobe is gated by the spad full flag.
module pe_out_stage #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  input  logic         full,
  output logic         in_ready,
  output logic         wr,
  output logic         val,
  output logic [W-1:0] data
);
  assign wr = val & ~full;
  assign in_ready = en & (~val | wr);
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      val  <= 1'b0;
      data <= '0;
    end else if (in_valid & in_ready) begin
      val  <= 1'b1;
      data <= in_data;
    end else if (wr) begin
      val  <= 1'b0;
    end
endmodule

// File: rtl/pe_spad_feeder.sv
// pe_spad_feeder: loads p*q*S filter pixels then ifmap_len ifmap pixels into one PE.
// Optional FEEDER_STALL_CNT_EN adds a saturating stall_cycles counter.
module pe_spad_feeder
  import pe_feeder_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int S_WIDTH    = S_WIDTH_DEF,
  parameter int p_WIDTH    = P_WIDTH_DEF,
  parameter int q_WIDTH    = Q_WIDTH_DEF,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 configure,
  input  logic [S_WIDTH-1:0]   S,
  input  logic [p_WIDTH-1:0]   p,
  input  logic [q_WIDTH-1:0]   q,
  input  logic [LEN_WIDTH-1:0] ifmap_len,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
`ifdef FEEDER_STALL_CNT_EN
  output logic [STALL_WIDTH-1:0] stall_cycles,
`endif
  pe_spad_feeder_if.master     bus
);
  localparam int FW = p_WIDTH + q_WIDTH + S_WIDTH;
  state_t state, state_nx;
  logic [S_WIDTH-1:0] s_q;
  logic [p_WIDTH-1:0] p_q;
  logic [q_WIDTH-1:0] q_q;
  logic [LEN_WIDTH-1:0] len_q, icnt;
  logic [FW-1:0] filter_len, fcnt;
  logic en_f, en_i, f_acc, i_acc, f_val, i_val, start_ok;
  assign filter_len = FW'(p_q) * FW'(q_q) * FW'(s_q);
  assign en_f = (state == LOAD_FILTER) && (filter_len != '0);
  assign en_i = (state == LOAD_IFMAP) && (len_q != '0);
  assign f_acc = bus.filter_in_valid & bus.filter_in_ready;
  assign i_acc = bus.ifmap_in_valid & bus.ifmap_in_ready;
  assign start_ok = (state == IDLE) & start;
  assign busy = state != IDLE;
  pe_out_stage #(.W(DATA_WIDTH)) u_filter (
    .clk(clk), .reset(reset), .en(en_f), .in_data(bus.filter_in), .in_valid(bus.filter_in_valid),
    .full(bus.filter_spad_full), .in_ready(bus.filter_in_ready), .wr(bus.wr_filter), .val(f_val),
    .data(bus.filter_pixel)
  );
  pe_out_stage #(.W(DATA_WIDTH)) u_ifmap (
    .clk(clk), .reset(reset), .en(en_i), .in_data(bus.ifmap_in), .in_valid(bus.ifmap_in_valid),
    .full(bus.ifmap_spad_full), .in_ready(bus.ifmap_in_ready), .wr(bus.wr_ifmap), .val(i_val),
    .data(bus.ifmap_pixel)
  );
  // Zero-length phases fall through because en_* stays low for them.
  always_comb begin
    state_nx = state;
    done = 1'b0;
    unique case (state)
      IDLE:        if (start) state_nx = LOAD_FILTER;
      LOAD_FILTER: if (!en_f || (f_acc && fcnt == filter_len - FW'(1))) state_nx = LOAD_IFMAP;
      LOAD_IFMAP:  if (!en_i || (i_acc && icnt == len_q - LEN_WIDTH'(1))) state_nx = DRAIN;
      DRAIN: if (!f_val && !i_val) begin
        done = 1'b1;
        state_nx = IDLE;
      end
      default:     state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      s_q   <= '0;
      p_q   <= '0;
      q_q   <= '0;
      len_q <= '0;
      fcnt  <= '0;
      icnt  <= '0;
    end else begin
      state <= state_nx;
      if (configure && state == IDLE) begin
        s_q   <= S;
        p_q   <= p;
        q_q   <= q;
        len_q <= ifmap_len;
      end
      if (start_ok) begin
        fcnt <= '0;
        icnt <= '0;
      end else begin
        if (f_acc) fcnt <= fcnt + FW'(1);
        if (i_acc) icnt <= icnt + LEN_WIDTH'(1);
      end
    end
`ifdef FEEDER_STALL_CNT_EN
  logic stall;
  assign stall = (f_val & bus.filter_spad_full) | (i_val & bus.ifmap_spad_full);
  always_ff @(posedge clk or negedge reset)
    if (!reset) stall_cycles <= '0;
    else if (start_ok) stall_cycles <= '0;
    else if (stall && stall_cycles != '1) stall_cycles <= stall_cycles + STALL_WIDTH'(1);
`endif
endmodule

// File: tb/tb_pe_spad_feeder.sv
// tb_pe_spad_feeder: scoreboard bench; upstream sources emit numbered pixels, expected PE writes queued per run.
module tb_pe_spad_feeder;
  logic clk, reset, configure, start, busy, done;
  logic [4:0] s_cfg, p_cfg;
  logic [2:0] q_cfg;
  logic [15:0] len_cfg;
`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif
  pe_spad_feeder_if #(.DATA_WIDTH(16)) intf ();
  pe_spad_feeder dut (
    .clk(clk), .reset(reset), .configure(configure), .S(s_cfg), .p(p_cfg), .q(q_cfg),
    .ifmap_len(len_cfg), .start(start), .busy(busy), .done(done),
`ifdef FEEDER_STALL_CNT_EN
    .stall_cycles(stall_cycles),
`endif
    .bus(intf)
  );
  int checks = 0, errors = 0;
  int fk = 0, ik = 0, cyc = 0, wf_cnt = 0, wi_cnt = 0, done_cnt = 0;
  int last_wf_cyc = 0, last_wi_cyc = 0, done_cyc = 0, exp_stall = 0;
  logic ff, fi, prev_ifull;
  logic [15:0] prev_ipix;
  logic [15:0] exp_f[$], exp_i[$];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask
  // Upstream sources and PE-side monitor: sample at negedge, advance sources just after posedge.
  initial begin
    prev_ifull = 1'b0;
    prev_ipix = '0;
    forever begin
      @(negedge clk);
      cyc++;
      ff = intf.filter_in_valid & intf.filter_in_ready;
      fi = intf.ifmap_in_valid & intf.ifmap_in_ready;
      if (intf.wr_filter) begin
        wf_cnt++;
        last_wf_cyc = cyc;
        if (exp_f.size() == 0) chk("f_extra", exp_f.size(), 1);
        else chk("f_data", 32'(intf.filter_pixel), 32'(exp_f.pop_front()));
      end
      if (intf.wr_ifmap) begin
        wi_cnt++;
        last_wi_cyc = cyc;
        if (exp_i.size() == 0) chk("i_extra", exp_i.size(), 1);
        else chk("i_data", 32'(intf.ifmap_pixel), 32'(exp_i.pop_front()));
      end
      if (intf.ifmap_spad_full) begin
        chk("i_wr_gated", 32'(intf.wr_ifmap), 0);
        if (prev_ifull) chk("i_hold", 32'(intf.ifmap_pixel), 32'(prev_ipix));
      end
      prev_ifull = intf.ifmap_spad_full;
      prev_ipix = intf.ifmap_pixel;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      @(posedge clk);
      #1;
      if (ff) fk++;
      if (fi) ik++;
      intf.filter_in = 16'(32'h1000 + fk);
      intf.ifmap_in = 16'(32'h2000 + ik);
    end
  end
  task automatic cfg(input int s, input int pp, input int qq, input int len);
    s_cfg = 5'(s);
    p_cfg = 5'(pp);
    q_cfg = 3'(qq);
    len_cfg = 16'(len);
    configure = 1'b1;
    @(posedge clk);
    #1 configure = 1'b0;
  endtask
  task automatic push_exp(input int flen, input int ilen);
    for (int n = 0; n < flen; n++) exp_f.push_back(16'(32'h1000 + fk + n));
    for (int n = 0; n < ilen; n++) exp_i.push_back(16'(32'h2000 + ik + n));
    wf_cnt = 0;
    wi_cnt = 0;
    done_cnt = 0;
  endtask
  task automatic run(input int flen, input int ilen);
    int n, fk0, ik0;
    logic busy_ok;
    fk0 = fk;
    ik0 = ik;
    push_exp(flen, ilen);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("busy_on", 32'(busy), 1);
    n = 0;
    busy_ok = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
      if (!busy) busy_ok = 1'b0;
    end
    chk("done_seen", 32'(done), 1);
    chk("busy_thru", 32'(busy_ok), 1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 0);
    chk("busy_off", 32'(busy), 0);
    chk("wf_cnt", wf_cnt, flen);
    chk("wi_cnt", wi_cnt, ilen);
    chk("done_cnt", done_cnt, 1);
    chk("f_left", exp_f.size(), 0);
    chk("i_left", exp_i.size(), 0);
    chk("f_used", fk - fk0, flen);
    chk("i_used", ik - ik0, ilen);
`ifdef FEEDER_STALL_CNT_EN
    chk("stall_cycles", 32'(stall_cycles), exp_stall);
`endif
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_wr"}, 32'({intf.wr_filter, intf.wr_ifmap}), 0);
    chk({tag, "_rdy"}, 32'({intf.filter_in_ready, intf.ifmap_in_ready}), 0);
    chk({tag, "_pix"}, {intf.filter_pixel, intf.ifmap_pixel}, 0);
  endtask
  initial begin
    int n, d0;
    reset = 1'b0;
    configure = 1'b0;
    start = 1'b0;
    s_cfg = '0;
    p_cfg = '0;
    q_cfg = '0;
    len_cfg = '0;
    intf.filter_in = 16'h1000;
    intf.ifmap_in = 16'h2000;
    intf.filter_in_valid = 1'b1;
    intf.ifmap_in_valid = 1'b1;
    intf.filter_spad_full = 1'b0;
    intf.ifmap_spad_full = 1'b0;
    repeat (2) @(posedge clk);
    #1 chk_zero("rst");
    reset = 1'b1;
    // basic run: 6 filter then 5 ifmap pixels
    cfg(3, 2, 1, 5);
    run(6, 5);
    chk("done_lat", done_cyc - last_wi_cyc, 1);
    // ifmap spad full for 4 cycles mid-stream
    exp_stall = 4;
    fork
      begin
        repeat (9) @(posedge clk);
        #1 intf.ifmap_spad_full = 1'b1;
        repeat (4) @(posedge clk);
        #1 intf.ifmap_spad_full = 1'b0;
      end
    join_none
    run(6, 5);
    chk("stall_done_lat", done_cyc - last_wi_cyc, 1);
    exp_stall = 0;
    // empty filter phase
    cfg(3, 0, 1, 3);
    run(0, 3);
    chk("f0_done_lat", done_cyc - last_wi_cyc, 1);
    // empty ifmap phase
    cfg(3, 2, 1, 0);
    run(6, 0);
    chk("i0_done_lat", done_cyc - last_wf_cyc, 1);
    chk("f_rdy_after", 32'(intf.filter_in_ready), 0);
    // reset during LOAD_IFMAP after two pixels
    cfg(3, 2, 1, 5);
    push_exp(6, 5);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    while (wi_cnt < 2 && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("abort_point", wi_cnt, 2);
    #1 reset = 1'b0;
    #1 chk_zero("abort");
    d0 = done_cnt;
    exp_f.delete();
    exp_i.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    chk("abort_no_done", done_cnt, d0);
    cfg(3, 2, 1, 5);
    run(6, 5);
    // start/configure while busy must not disturb the run or latched config
    fork
      begin
        repeat (3) @(posedge clk);
        #1;
        s_cfg = 5'd1;
        p_cfg = 5'd1;
        q_cfg = 3'd1;
        len_cfg = 16'd1;
        configure = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        configure = 1'b0;
        start = 1'b0;
      end
    join_none
    run(6, 5);
    run(6, 5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
